// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette lookup block.
// Default widths match the VGA pixel path (4-bit index, 4-bit channels, 2 banks).
package palette_pkg;

  localparam int PAL_IDX_W = 4;
  localparam int PAL_CH_W  = 4;
  localparam int PAL_BANKS = 2;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  // Bank select width; a single-bank palette still carries a 1-bit select.
  function automatic int bk_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // Grey-ramp channel value for entry i, spread evenly across the channel range.
  function automatic int grey_level(input int i, input int idx_w, input int ch_w);
    return (i * ((1 << ch_w) - 1)) / ((1 << idx_w) - 1);
  endfunction

endpackage

// File: rtl/palette_fade.sv
// Single-stage brightness scaler: each channel becomes (c * (level + 1)) >> CH_W.
// Only instantiated when PALETTE_FADE_EN is defined.
module palette_fade #(
  parameter int CH_W = 4,
  localparam int RGB_W = 3 * CH_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [RGB_W-1:0] rgb_i,
  input  logic [CH_W-1:0]  level_i,
  output logic             valid_o,
  output logic [RGB_W-1:0] rgb_o
);

  logic             valid_q;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                            input logic [CH_W-1:0] lvl);
    logic [2*CH_W-1:0] p;
    p = (2*CH_W)'(c) * ((2*CH_W)'(lvl) + (2*CH_W)'(1));
    return CH_W'(p >> CH_W);
  endfunction

  // Scale all three channels; blanked pixels stay black.
  always_comb begin
    rgb_d = '0;
    if (valid_i) begin
      rgb_d = {scale(rgb_i[3*CH_W-1:2*CH_W], level_i),
               scale(rgb_i[2*CH_W-1:CH_W],   level_i),
               scale(rgb_i[CH_W-1:0],        level_i)};
    end
  end

  // Output register; valid passes straight through one stage behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      valid_q <= valid_i;
      rgb_q   <= rgb_d;
    end
  end

  assign valid_o = valid_q;
  assign rgb_o   = rgb_q;

endmodule

// File: rtl/palette_lut.sv
// Multi-bank runtime-programmable colour palette with frame-aligned bank switching.
// Define PALETTE_FADE_EN to add the fade_level port and a brightness stage (latency 2).
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W = PAL_IDX_W,
  parameter int CH_W  = PAL_CH_W,
  parameter int BANKS = PAL_BANKS,
  localparam int BK_W  = bk_w(BANKS),
  localparam int DEPTH = 1 << IDX_W,
  localparam int RGB_W = 3 * CH_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_valid,
  input  logic [IDX_W-1:0] pix_index,
  input  logic             frame_start,
  input  logic             bank_req,
  input  logic [BK_W-1:0]  bank_req_sel,
  input  logic             wr_en,
  input  logic [BK_W-1:0]  wr_bank,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [RGB_W-1:0] wr_rgb,
`ifdef PALETTE_FADE_EN
  input  logic [CH_W-1:0]  fade_level,
`endif
  output logic             out_valid,
  output logic [CH_W-1:0]  red,
  output logic [CH_W-1:0]  green,
  output logic [CH_W-1:0]  blue,
  output logic [BK_W-1:0]  active_bank
);

  logic [RGB_W-1:0] pal_q [BANKS][DEPTH];
  logic [BK_W-1:0]  active_bank_q, pending_q;
  logic             s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
  logic             wr_ok, req_ok;
  logic             out_v;
  logic [RGB_W-1:0] out_rgb;

  function automatic logic [RGB_W-1:0] grey_entry(input int i);
    logic [CH_W-1:0] c;
    c = CH_W'(grey_level(i, IDX_W, CH_W));
    return {c, c, c};
  endfunction

  // Selects naming a non-existent bank are dropped.
  assign wr_ok  = wr_en    && (32'(wr_bank)      < BANKS);
  assign req_ok = bank_req && (32'(bank_req_sel) < BANKS);

  // Palette storage: grey ramp on reset, single-entry writes afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          pal_q[b][i] <= grey_entry(i);
        end
      end
    end else if (wr_ok) begin
      pal_q[wr_bank][wr_addr] <= wr_rgb;
    end
  end

  // Bank double-buffer: frame_start promotes the pending bank seen before this edge,
  // so a request in the same cycle only lands for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_bank_q <= '0;
      pending_q     <= '0;
    end else begin
      if (frame_start) active_bank_q <= pending_q;
      if (req_ok)      pending_q     <= bank_req_sel;
    end
  end

  // Lookup reads the pre-write contents and the currently registered bank.
  always_comb begin
    s1_valid_d = pix_valid;
    s1_rgb_d   = '0;
    if (pix_valid) s1_rgb_d = pal_q[active_bank_q][pix_index];
  end

  // Stage-1 lookup register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rgb_q   <= s1_rgb_d;
    end
  end

`ifdef PALETTE_FADE_EN
  palette_fade #(.CH_W(CH_W)) u_fade (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .valid_i (s1_valid_q),
    .rgb_i   (s1_rgb_q),
    .level_i (fade_level),
    .valid_o (out_v),
    .rgb_o   (out_rgb)
  );
`else
  assign out_v   = s1_valid_q;
  assign out_rgb = s1_rgb_q;
`endif

  assign out_valid   = out_v;
  assign red         = out_rgb[3*CH_W-1:2*CH_W];
  assign green       = out_rgb[2*CH_W-1:CH_W];
  assign blue        = out_rgb[CH_W-1:0];
  assign active_bank = active_bank_q;

endmodule

// File: doc/palette_lut.md
# palette_lut

Runtime-programmable, multi-bank colour palette for the VGA pixel path. Maps a per-pixel colour index to RGB through a registered lookup, with double-buffered bank switching aligned to frame boundaries so sprites and floor tiles can swap palettes without mid-frame tearing. Sits between the sprite/tile ROM index outputs and the VGA colour mapper, replacing the fixed per-asset palette ROMs.

## Interface
- IDX_W, 4, colour index width; palette depth is 2^IDX_W entries
- CH_W, 4, bits per colour channel
- BANKS, 2, number of palette banks (>=1); BK_W = max(1, $clog2(BANKS))
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  pixel index valid this cycle
- pix_index  in  IDX_W  colour index
- frame_start  in  1  one-cycle pulse at start of frame (vsync edge)
- bank_req  in  1  latch bank_req_sel as pending bank
- bank_req_sel  in  BK_W  requested bank
- wr_en  in  1  write one palette entry
- wr_bank  in  BK_W  target bank of write
- wr_addr  in  IDX_W  target entry
- wr_rgb  in  3*CH_W  {r,g,b} write data
- fade_level  in  CH_W  global brightness (present only with PALETTE_FADE_EN)
- out_valid  out  1  colour outputs valid
- red, green, blue  out  CH_W each  looked-up colour
- active_bank  out  BK_W  bank currently used for lookups

## Operation
- Storage: BANKS x 2^IDX_W entries of 3*CH_W bits, flop-based, any bank writable at any time.
- Reset: every entry of every bank loads the grey ramp: each channel = floor(i*(2^CH_W-1)/(2^IDX_W-1)) for entry i (IDX_W=CH_W=4 gives i). active_bank=0, pending bank=0, out_valid=0, red/green/blue=0.
- Write: on wr_en, entry [wr_bank][wr_addr] <= wr_rgb at the clock edge. wr_bank >= BANKS ignored.
- Bank request: bank_req latches bank_req_sel into pending; later requests before frame_start overwrite earlier ones. bank_req_sel >= BANKS ignored.
- Bank switch: on frame_start, active_bank <= pending. bank_req and frame_start in same cycle: frame_start applies the old pending value; the new request lands in pending and takes effect at the next frame_start.
- Lookup: pixel sampled with pix_valid uses active_bank as registered in that cycle (old bank in the frame_start cycle).
- Blanking: when out_valid=0, red/green/blue are driven 0.
- Index/channel arithmetic unsigned; no saturation needed outside fade.

## Timing
- Lookup latency 1 cycle without fade: pix_valid at cycle N -> out_valid and colour at N+1. Fully pipelined, one pixel per cycle, no back-pressure.
- Read-during-write to the same entry: lookup returns the pre-write value; the new value is visible to lookups sampled from the following cycle.
- active_bank changes the cycle after frame_start.
- Reset asserted mid-stream: all outputs clear asynchronously; in-flight pixels are dropped; palette contents revert to grey ramp.

## Configuration
- PALETTE_FADE_EN defined: adds fade_level port and one extra pipeline stage (latency 2). Each channel out = (c*(fade_level+1)) >> CH_W; fade_level=2^CH_W-1 passes colour unchanged, fade_level=0 yields 0 for all c. fade_level sampled in the same cycle as the stage-1 colour (one cycle after pix_valid).
- Not defined: no fade_level port, latency 1, colour passes through unscaled.

## Structure
- palette_pkg: rgb_t packed struct {r,g,b} parametrised via CH_W localparams, grey-ramp init function, BK_W computation.
- Sub-module palette_fade: single-stage per-channel scaler with valid pass-through; instantiated only under PALETTE_FADE_EN.

## Test plan
- Reset then pix_index=0..15 consecutively, bank 0 -> outputs 0x0..0xF grey, each one cycle after input, out_valid tracks pix_valid.
- Write bank1 entry 5 = {F,0,0}, bank_req sel=1, lookup index 5 before frame_start -> grey 5; after frame_start -> {F,0,0}; active_bank=1 from the following cycle.
- wr_en to bank0 entry 3 = {0,F,0} same cycle as lookup of index 3 -> output grey 3; lookup next cycle -> {0,F,0}.
- bank_req sel=1 coincident with frame_start with pending=0 -> active_bank stays 0; next frame_start -> 1.
- PALETTE_FADE_EN: entry {F,8,1}, fade_level=7 -> {7,4,0} two cycles later; fade_level=15 -> {F,8,1}; fade_level=0 -> {0,0,0}.
- reset_n low during streaming -> out_valid/colour/active_bank 0 immediately; previously written entries read back as grey ramp after release.
